// File: rtl/dpram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// dpram_fifo_ctrl
//
// Synchronous FIFO controller wrapped around a 32x32 two-port fakeram macro
// (port A = read, port B = write, both enables active-low). The macro's
// 1-cycle read latency is hidden behind a 2-entry output skid buffer. Its
// "QA is garbage while CENB is low" quirk is hidden behind a 1-entry write
// holding buffer (wbuf). That buffer is only drained in cycles that are not
// read-capture cycles.
//
// Ports:
//   clk_i        single clock, also feeds the macro CLKA/CLKB
//   reset_i      synchronous, active-high reset
//   v_i/data_i   enqueue valid/data; transfer when v_i & ready_o
//   ready_o      enqueue ready
//   v_o/data_o   dequeue valid / head data
//   yumi_i       dequeue accept (ignored when v_o=0)
//   ram_cena_o   macro CENA (active-low read enable)
//   ram_aa_o     macro AA (read address)
//   ram_qa_i     macro QA (read data, one cycle after CENA low)
//   ram_cenb_o   macro CENB (active-low write enable)
//   ram_ab_o     macro AB (write address)
//   ram_db_o     macro DB (write data)
//   count_o      (only with DPRAM_FIFO_COUNT_EN) registered total occupancy
//
// Optional build macro: DPRAM_FIFO_COUNT_EN adds count_o.
// ---------------------------------------------------------------------------
module dpram_fifo_ctrl #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              v_i,
  input  logic [WIDTH-1:0]  data_i,
  output logic              ready_o,
  output logic              v_o,
  output logic [WIDTH-1:0]  data_o,
  input  logic              yumi_i,
  output logic              ram_cena_o,
  output logic [ADDR_W-1:0] ram_aa_o,
  input  logic [WIDTH-1:0]  ram_qa_i,
  output logic              ram_cenb_o,
  output logic [ADDR_W-1:0] ram_ab_o,
`ifdef DPRAM_FIFO_COUNT_EN
  output logic [WIDTH-1:0]  ram_db_o,
  output logic [ADDR_W+2:0] count_o
`else
  output logic [WIDTH-1:0]  ram_db_o
`endif
);

  localparam logic [ADDR_W:0]   PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(DEPTH);

  // RAM pointers carry an extra wrap bit so full and empty differ.
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   ram_used;
  logic [ADDR_W+1:0] ram_pending;

  logic              wbuf_v;
  logic [WIDTH-1:0]  wbuf_q;

  logic              rd_inflight;

  logic [WIDTH-1:0]  obuf_mem [2];
  logic              obuf_head;
  logic              obuf_tail;
  logic [1:0]        obuf_cnt;
  logic [2:0]        obuf_occ;
  logic [2:0]        obuf_lim;

  logic              enq;
  logic              drain;
  logic              issue;
  logic              push;
  logic              pop;

  assign ram_used    = wr_ptr - rd_ptr;
  assign ram_pending = {1'b0, ram_used} + {{(ADDR_W+1){1'b0}}, wbuf_v};

  // Enqueue is refused while wbuf is stuck behind a capture cycle, because
  // wbuf cannot drain in that cycle and has only one slot.
  assign ready_o = ~reset_i & (~wbuf_v | ~rd_inflight) & (ram_pending < DEPTH_W);
  assign enq     = v_i & ready_o;

  assign v_o    = ~reset_i & (obuf_cnt != 2'd0);
  assign pop    = yumi_i & v_o;
  assign data_o = v_o ? obuf_mem[obuf_head] : '0;

  // Writes never share a cycle with a read capture: QA is corrupt while CENB
  // is low.
  assign drain = ~reset_i & wbuf_v & ~rd_inflight;

  // A read may issue only if the obuf has room for it once the word already
  // in flight lands, counting a pop happening this cycle. Reads are held off
  // while wbuf waits behind a capture, so wbuf drains within 2 cycles.
  assign obuf_occ = {1'b0, obuf_cnt} + {2'b00, rd_inflight};
  assign obuf_lim = 3'd2 + {2'b00, pop};
  assign issue    = ~reset_i & (ram_used != '0) & (obuf_occ < obuf_lim)
                    & ~(wbuf_v & rd_inflight);

  assign push      = rd_inflight;
  assign obuf_tail = obuf_head ^ (obuf_cnt == 2'd1);

  assign ram_cenb_o = ~drain;
  assign ram_ab_o   = drain ? wr_ptr[ADDR_W-1:0] : '0;
  assign ram_db_o   = drain ? wbuf_q : '0;

  assign ram_cena_o = ~issue;
  assign ram_aa_o   = issue ? rd_ptr[ADDR_W-1:0] : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      wbuf_v      <= 1'b0;
      wbuf_q      <= '0;
      rd_inflight <= 1'b0;
      obuf_head   <= 1'b0;
      obuf_cnt    <= 2'd0;
    end else begin
      if (drain) wr_ptr <= wr_ptr + PTR_ONE;
      if (issue) rd_ptr <= rd_ptr + PTR_ONE;

      // A new word can load in the same cycle the old one drains.
      if (enq) begin
        wbuf_v <= 1'b1;
        wbuf_q <= data_i;
      end else if (drain) begin
        wbuf_v <= 1'b0;
      end

      rd_inflight <= issue;

      if (pop) obuf_head <= ~obuf_head;

      case ({push, pop})
        2'b10:   obuf_cnt <= obuf_cnt + 2'd1;
        2'b01:   obuf_cnt <= obuf_cnt - 2'd1;
        default: obuf_cnt <= obuf_cnt;
      endcase
    end
  end

  // Capture storage needs no reset: obuf_cnt decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (!reset_i && push) obuf_mem[obuf_tail] <= ram_qa_i;
  end

`ifdef DPRAM_FIFO_COUNT_EN
  // Tracks every word held anywhere (wbuf, RAM, in flight, obuf). Only
  // accepted enqueues and pops change it.
  logic [ADDR_W+2:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + {{(ADDR_W+2){1'b0}}, enq} - {{(ADDR_W+2){1'b0}}, pop};
    end
  end

  assign count_o = count_q;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
module tb_dpram_fifo_ctrl;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              v_i;
  logic [WIDTH-1:0]  data_i;
  logic              ready_o;
  logic              v_o;
  logic [WIDTH-1:0]  data_o;
  logic              yumi_i;
  logic              ram_cena_o;
  logic [ADDR_W-1:0] ram_aa_o;
  logic [WIDTH-1:0]  ram_qa_i;
  logic              ram_cenb_o;
  logic [ADDR_W-1:0] ram_ab_o;
  logic [WIDTH-1:0]  ram_db_o;
`ifdef DPRAM_FIFO_COUNT_EN
  logic [ADDR_W+2:0] count_o;
`endif

  always #5 clk_i = ~clk_i;

  dpram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
    .ram_cena_o(ram_cena_o), .ram_aa_o(ram_aa_o), .ram_qa_i(ram_qa_i),
    .ram_cenb_o(ram_cenb_o), .ram_ab_o(ram_ab_o),
`ifdef DPRAM_FIFO_COUNT_EN
    .count_o(count_o),
`endif
    .ram_db_o(ram_db_o)
  );

  // Two-port macro model: 1-cycle read latency; QA is garbage while CENB low.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] qa_r = '0;
  always @(posedge clk_i) begin
    if (!ram_cena_o) qa_r <= mem[ram_aa_o];
    if (!ram_cenb_o) mem[ram_ab_o] <= ram_db_o;
  end
  assign ram_qa_i = ram_cenb_o ? qa_r : 32'hBADC0DE0;

  int vectors = 0;
  int miscompares = 0;
  int wraps = 0;
  logic prev_rd = 1'b0;
  logic [WIDTH-1:0] exp_q [$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void timeout(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endfunction

  // Scoreboard producer: expected data recorded at each accepted enqueue.
  always @(negedge clk_i) begin
    if (!reset_i && v_i && ready_o) exp_q.push_back(data_i);
  end

  // Monitor: compare head data on every dequeue; watch write/capture overlap.
  always @(negedge clk_i) begin
    if (!reset_i && v_o && yumi_i) begin
      if (exp_q.size() == 0) timeout("sb_unexpected_output");
      else chk("sb_data", data_o, exp_q.pop_front());
    end
    if (prev_rd) chk("no_write_in_capture", ram_cenb_o, 1'b1);
    prev_rd = !ram_cena_o && !reset_i;
    if (!reset_i && !ram_cenb_o && ram_ab_o == ADDR_W'(DEPTH-1)) wraps++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    bit ok = 0;
    v_i = 1'b1;
    data_i = d;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_i);
      if (ready_o) begin ok = 1; break; end
      tick();
    end
    if (!ok) timeout("send");
    tick();
    v_i = 1'b0;
  endtask

  task automatic pop_one();
    bit ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_i);
      if (v_o) begin ok = 1; break; end
      tick();
    end
    if (!ok) timeout("pop_wait_v_o");
    tick();
    yumi_i = ok;
    @(negedge clk_i);
    tick();
    yumi_i = 1'b0;
  endtask

  initial begin
    int idx;
    int pops;
    int sent;
    int rcvd;
    int cyc;
    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; data_i = '0;

    // Reset values
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      chk("rst_cena", ram_cena_o, 1'b1);
      chk("rst_cenb", ram_cenb_o, 1'b1);
      chk("rst_aa", ram_aa_o, 0);
      chk("rst_ab", ram_ab_o, 0);
      chk("rst_db", ram_db_o, 0);
      chk("rst_v_o", v_o, 1'b0);
      chk("rst_data_o", data_o, 0);
      chk("rst_ready", ready_o, 1'b0);
      tick();
    end
    reset_i = 1'b0;

    // Idle 5 cycles
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      chk("idle_ready", ready_o, 1'b1);
      chk("idle_v_o", v_o, 1'b0);
      chk("idle_cena", ram_cena_o, 1'b1);
      chk("idle_cenb", ram_cenb_o, 1'b1);
      tick();
    end

    // Single-word latency: accept at cycle 0, write 1, read 2, valid 4
    v_i = 1'b1; data_i = 32'hDEADBEEF;
    @(negedge clk_i); chk("lat_c0_ready", ready_o, 1'b1);
    tick(); v_i = 1'b0;
    @(negedge clk_i);
    chk("lat_c1_cenb", ram_cenb_o, 1'b0);
    chk("lat_c1_ab", ram_ab_o, 0);
    chk("lat_c1_db", ram_db_o, 32'hDEADBEEF);
    chk("lat_c1_cena", ram_cena_o, 1'b1);
    tick();
    @(negedge clk_i);
    chk("lat_c2_cena", ram_cena_o, 1'b0);
    chk("lat_c2_aa", ram_aa_o, 0);
    tick();
    @(negedge clk_i); chk("lat_c3_v_o", v_o, 1'b0);
    tick();
    yumi_i = 1'b1;
    @(negedge clk_i);
    chk("lat_c4_v_o", v_o, 1'b1);
    chk("lat_c4_data", data_o, 32'hDEADBEEF);
    tick(); yumi_i = 1'b0;
    @(negedge clk_i); chk("lat_c5_v_o", v_o, 1'b0);

    // Fill with 0..35, no dequeue: 34 fit (32 RAM + 2 obuf)
    idx = 0;
    for (int c = 0; c < 120; c++) begin
      tick();
      v_i = (idx < 36);
      data_i = 32'(idx);
      @(negedge clk_i);
      if (v_i && ready_o) idx++;
    end
    chk("fill_accepted", 32'(idx), 34);
    chk("fill_ready_low", ready_o, 1'b0);
    tick(); v_i = 1'b0;

    // Drain in order 0..33 (data checked by scoreboard)
    pops = 0;
    for (int c = 0; c < 300 && pops < 34; c++) begin
      tick();
      yumi_i = v_o;
      @(negedge clk_i);
      if (v_o && yumi_i) pops++;
    end
    tick(); yumi_i = 1'b0;
    chk("drain_pops", 32'(pops), 34);
    @(negedge clk_i);
    chk("drain_v_o", v_o, 1'b0);
    chk("drain_sb_empty", 32'(exp_q.size()), 0);

    // Random streaming of 200 words
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 200 && cyc < 5000) begin
      tick();
      v_i = (sent < 200) && ($urandom_range(9) < 7);
      data_i = $urandom;
      yumi_i = v_o && ($urandom_range(9) < 6);
      @(negedge clk_i);
      if (v_i && ready_o) sent++;
      if (v_o && yumi_i) rcvd++;
      cyc++;
    end
    tick(); v_i = 1'b0; yumi_i = 1'b0;
    chk("stream_rcvd", 32'(rcvd), 200);
    chk("stream_sb_empty", 32'(exp_q.size()), 0);
    chk("stream_wraps_ge6", 32'(wraps >= 6), 1);

    // Reset mid-operation with a read in flight and obuf non-empty
    send(32'h11); send(32'h22); send(32'h33); send(32'h44);
    for (int c = 0; c < 12; c++) tick();
    @(negedge clk_i); chk("mid_v_o_before", v_o, 1'b1);
    tick(); yumi_i = 1'b1;
    @(negedge clk_i); chk("mid_pop_issues_read", ram_cena_o, 1'b0);
    tick(); yumi_i = 1'b0; reset_i = 1'b1;
    exp_q.delete();
    @(negedge clk_i);
    chk("mid_rst_v_o", v_o, 1'b0);
    chk("mid_rst_ready", ready_o, 1'b0);
    chk("mid_rst_cenb", ram_cenb_o, 1'b1);
    tick(); reset_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_v_o", v_o, 1'b0);
    chk("post_rst_ready", ready_o, 1'b1);
`ifdef DPRAM_FIFO_COUNT_EN
    chk("post_rst_count", count_o, 0);
`endif
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk_i);
      chk("post_rst_quiet_v_o", v_o, 1'b0);
      chk("post_rst_quiet_cena", ram_cena_o, 1'b1);
    end
    tick();
    send(32'h5);
    pop_one();
    chk("post_rst_sb_empty", 32'(exp_q.size()), 0);

`ifdef DPRAM_FIFO_COUNT_EN
    // Occupancy counter: 1,2,3 then 2 after one dequeue
    send(32'hA1); @(negedge clk_i); chk("count_1", count_o, 1);
    tick();
    send(32'hA2); @(negedge clk_i); chk("count_2", count_o, 2);
    tick();
    send(32'hA3); @(negedge clk_i); chk("count_3", count_o, 3);
    tick();
    pop_one();
    @(negedge clk_i); chk("count_after_pop", count_o, 2);
    tick();
    pop_one();
    pop_one();
    @(negedge clk_i); chk("count_empty", count_o, 0);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
